// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, widths, operand-stage request struct and forwarding helper
package alu_pkg;
  localparam int DATA_W = 64;
  localparam int TAG_W = 5;
  localparam int ALU_OP_W = 12;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 12'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 12'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 12'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR = 12'd3;
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0] rd;
  } alu_req_t;
  // Youngest valid producer wins; tag 0 and faulting ops never forward.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [TAG_W-1:0] rs, input logic [DATA_W-1:0] dflt,
    input logic s1_valid, input alu_req_t s1, input logic [DATA_W-1:0] alu_q,
    input logic s2_valid, input logic [TAG_W-1:0] s2_rd, input logic s2_err,
    input logic [DATA_W-1:0] s2_q);
    return (rs == '0) ? dflt :
           (s1_valid && s1.rd == rs && s1.op <= ALU_OP_OR) ? alu_q :
           (s2_valid && s2_rd == rs && !s2_err) ? s2_q : dflt;
  endfunction
endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: issue-side and writeback-side valid/ready bundle
// slave: the exec stage (takes in_*, out_ready; drives in_ready, out_*)
// master: the surrounding pipeline (drives in_*, out_ready)
interface alu_exec_stage_if
  import alu_pkg::*;
#(parameter int OPERANDSIZE = DATA_W, parameter int REGADDRW = TAG_W);
  logic in_valid, in_ready;
  logic [ALU_OP_W-1:0] in_op;
  logic [OPERANDSIZE-1:0] in_a, in_b;
  logic [REGADDRW-1:0] in_rd, in_rs_a, in_rs_b;
  logic out_valid, out_ready, out_err;
  logic [OPERANDSIZE-1:0] out_q;
  logic [REGADDRW-1:0] out_rd;
  modport slave (
    input in_valid, in_op, in_a, in_b, in_rd, in_rs_a, in_rs_b, out_ready,
    output in_ready, out_valid, out_q, out_rd, out_err
  );
  modport master (
    output in_valid, in_op, in_a, in_b, in_rd, in_rs_a, in_rs_b, out_ready,
    input in_ready, out_valid, out_q, out_rd, out_err
  );
endinterface

// File: rtl/alu.sv
// alu: combinational ADD/XOR/AND/OR; unsupported opcodes give 0
// ports: a, b operands; operationSelect opcode; q result
module alu
  import alu_pkg::*;
#(parameter int W = DATA_W) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [ALU_OP_W-1:0] operationSelect,
  output logic [W-1:0] q
);
  always_comb
    q = (operationSelect == ALU_OP_ADD) ? a + b :
        (operationSelect == ALU_OP_XOR) ? a ^ b :
        (operationSelect == ALU_OP_AND) ? a & b :
        (operationSelect == ALU_OP_OR)  ? a | b : '0;
endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: one-entry valid/ready register slice for an arbitrary payload type
// ports: clk, rst (async high); in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream
module pipe_reg #(parameter type T = logic) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  assign in_ready = !out_valid || out_ready;
  // When open, the slot either refills or empties; when blocked, it holds.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-deep execute stage (S1 operands -> ALU -> S2 result) with back-pressure
// ports: clk, rst (async high); bus: alu_exec_stage_if.slave (issue in_*, writeback out_*)
// ALU_EXEC_BYPASS_EN: forward S1/S2 results into operands at accept by source tag
module alu_exec_stage
  import alu_pkg::*;
#(parameter int OPERANDSIZE = DATA_W, parameter int REGADDRW = TAG_W) (
  input logic clk,
  input logic rst,
  alu_exec_stage_if.slave bus
);
  typedef struct packed {
    logic [OPERANDSIZE-1:0] q;
    logic [REGADDRW-1:0] rd;
    logic err;
  } res_t;
  alu_req_t req, s1;
  res_t res, s2;
  logic s1_valid, s2_ready;
  logic [OPERANDSIZE-1:0] alu_q, op_a, op_b;
`ifdef ALU_EXEC_BYPASS_EN
  always_comb begin
    op_a = fwd_sel(bus.in_rs_a, bus.in_a, s1_valid, s1, alu_q, bus.out_valid, s2.rd, s2.err, s2.q);
    op_b = fwd_sel(bus.in_rs_b, bus.in_b, s1_valid, s1, alu_q, bus.out_valid, s2.rd, s2.err, s2.q);
  end
`else
  assign op_a = bus.in_a;
  assign op_b = bus.in_b;
`endif
  assign req = '{op: bus.in_op, a: op_a, b: op_b, rd: bus.in_rd};
  pipe_reg #(.T(alu_req_t)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(bus.in_valid), .in_ready(bus.in_ready), .in_data(req),
    .out_valid(s1_valid), .out_ready(s2_ready), .out_data(s1)
  );
  alu #(.W(OPERANDSIZE)) u_alu (.a(s1.a), .b(s1.b), .operationSelect(s1.op), .q(alu_q));
  assign res = '{q: alu_q, rd: s1.rd, err: s1.op > ALU_OP_OR};
  pipe_reg #(.T(res_t)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(s1_valid), .in_ready(s2_ready), .in_data(res),
    .out_valid(bus.out_valid), .out_ready(bus.out_ready), .out_data(s2)
  );
  assign bus.out_q = s2.q;
  assign bus.out_rd = s2.rd;
  assign bus.out_err = s2.err;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed checks of reset, latency, stall, bad opcode, async reset, bypass
module tb_alu_exec_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  alu_exec_stage_if bus ();
  alu_exec_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] rd, input logic [4:0] rs_a, input logic [4:0] rs_b);
    bus.in_valid = 1'b1;
    bus.in_op = op;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_rd = rd;
    bus.in_rs_a = rs_a;
    bus.in_rs_b = rs_b;
  endtask

  logic [63:0] byp_exp;

  initial begin
    bus.out_ready = 1'b1;
    send(12'd0, 64'd1, 64'd1, 5'd1, 5'd0, 5'd0);
    repeat (3) step();
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_q", bus.out_q, 64'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_no_output", {63'd0, bus.out_valid}, 64'd0);
    end

    send(12'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 5'd0, 5'd0);
    step();
    bus.in_valid = 1'b0;
    chk("single_lat1", {63'd0, bus.out_valid}, 64'd0);
    step();
    chk("single_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("single_q", bus.out_q, 64'd0);
    chk("single_rd", {59'd0, bus.out_rd}, 64'd7);
    chk("single_err", {63'd0, bus.out_err}, 64'd0);
    step();
    chk("single_drained", {63'd0, bus.out_valid}, 64'd0);

    bus.out_ready = 1'b0;
    send(12'd1, 64'd5, 64'd3, 5'd1, 5'd0, 5'd0);
    step();
    send(12'd2, 64'd6, 64'd3, 5'd2, 5'd0, 5'd0);
    #1;
    chk("stall_ready_2nd", {63'd0, bus.in_ready}, 64'd1);
    step();
    send(12'd3, 64'd8, 64'd1, 5'd3, 5'd0, 5'd0);
    #1;
    chk("stall_ready_3rd", {63'd0, bus.in_ready}, 64'd0);
    step();
    chk("stall_hold_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("stall_hold_q", bus.out_q, 64'd6);
    step();
    chk("stall_hold_q2", bus.out_q, 64'd6);
    chk("stall_hold_rd", {59'd0, bus.out_rd}, 64'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("stall_res0", bus.out_q, 64'd6);
    step();
    bus.in_valid = 1'b0;
    chk("stall_res1_v", {63'd0, bus.out_valid}, 64'd1);
    chk("stall_res1", bus.out_q, 64'd2);
    chk("stall_res1_rd", {59'd0, bus.out_rd}, 64'd2);
    step();
    chk("stall_res2", bus.out_q, 64'd9);
    chk("stall_res2_rd", {59'd0, bus.out_rd}, 64'd3);
    step();
    chk("stall_empty", {63'd0, bus.out_valid}, 64'd0);

    send(12'd9, 64'd4, 64'd4, 5'd3, 5'd0, 5'd0);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("bad_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("bad_q", bus.out_q, 64'd0);
    chk("bad_err", {63'd0, bus.out_err}, 64'd1);
    chk("bad_rd", {59'd0, bus.out_rd}, 64'd3);
    step();

    bus.out_ready = 1'b0;
    send(12'd0, 64'd1, 64'd1, 5'd1, 5'd0, 5'd0);
    step();
    send(12'd0, 64'd3, 64'd3, 5'd2, 5'd0, 5'd0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("mid_full_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("mid_full_q", bus.out_q, 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_q", bus.out_q, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.in_ready}, 64'd1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    send(12'd0, 64'd2, 64'd2, 5'd6, 5'd0, 5'd0);
    step();
    bus.in_valid = 1'b0;
    chk("mid_no_stale", {63'd0, bus.out_valid}, 64'd0);
    step();
    chk("mid_add_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("mid_add_q", bus.out_q, 64'd4);
    chk("mid_add_rd", {59'd0, bus.out_rd}, 64'd6);
    step();

    send(12'd0, 64'd10, 64'd5, 5'd4, 5'd0, 5'd0);
    step();
    send(12'd0, 64'd0, 64'd1, 5'd5, 5'd4, 5'd0);
    step();
    bus.in_valid = 1'b0;
    chk("byp_first", bus.out_q, 64'd15);
    chk("byp_first_rd", {59'd0, bus.out_rd}, 64'd4);
    step();
`ifdef ALU_EXEC_BYPASS_EN
    byp_exp = 64'd16;
`else
    byp_exp = 64'd1;
`endif
    chk("byp_second", bus.out_q, byp_exp);
    chk("byp_second_rd", {59'd0, bus.out_rd}, 64'd5);
    step();
    chk("byp_empty", {63'd0, bus.out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
